mole_scheduler: RTL
===================

Name: mole_scheduler

Overview:
- Sequencing controller for the whack-a-mole datapath. Decides when and where moles appear, ages each mole, and retires it on a hit or on timeout.
- Sits between the game FSM (start/end), a spawn-rate divider tick, a free-running random source, and the switch-selected hit input.
- Drives the per-hole mole mask and single-cycle hit/miss/escape events into the score keeper and display.

Parameters:
NUM_HOLES, 5, number of mole holes; bit i of every mask = hole i+1
LIFE_TICKS, 8, spawn ticks a mole stays up before escaping (1..15)
MAX_ACTIVE, 2, maximum simultaneous moles (1..NUM_HOLES)
LIFE_W, 4, width of per-hole life counter

Ports:
clock  in  1  system clock; all state on rising edge
resetn  in  1  asynchronous, active-low reset
start  in  1  level; begins a round when in IDLE
game_end  in  1  level; countdown expired, stop spawning
spawn_tick  in  1  one-cycle enable from rate divider; timing base for spawn and aging
rand_sel  in  3  random hole candidate; 0..4 select hole 1..5, 5..7 mean no spawn
hit_sel  in  3  user hole select; 0 = none, 1..5 = hole 1..5, 6..7 treated as none
moles_active  out  NUM_HOLES  current mole mask
hit_pulse  out  1  one cycle: active mole whacked
miss_pulse  out  1  one cycle: empty hole whacked
escape_pulse  out  1  one cycle: at least one mole timed out this cycle
active_count  out  3  popcount of moles_active
busy  out  1  high in RUN and DRAIN
done_pulse  out  1  one cycle on DRAIN->IDLE

Behaviour:
- Reset (resetn=0, async): state=IDLE; moles_active=0; all life counters=0; all pulses=0; busy=0; active_count=0; hit history=0.
- States: IDLE, RUN, DRAIN.
- IDLE: no spawning. Hits are ignored (no pulses). start=1 -> RUN next cycle, with all slots cleared.
- RUN, on a spawn_tick cycle:
  (a) Every active hole decrements its life. A hole whose life is 1 before the decrement is cleared, and escape_pulse is asserted that cycle.
  (b) Spawn if rand_sel<5, the target hole is not active, the target hole is not the subject of a same-cycle hit, and active_count (pre-cycle) < MAX_ACTIVE.
  (c) A spawned mole sets its bit and loads life=LIFE_TICKS. It is not decremented on its spawn tick.
- Hit detection: hit_sel is registered. An event occurs on a cycle where hit_sel is valid (1..5) and differs from the previous registered value. Holding the switches produces exactly one event; returning to 0 then reselecting produces a new event.
- Hit event on an active hole: clear that bit, hit_pulse=1 the same cycle as the event (registered output, 1-cycle latency from the hit_sel sample).
- Hit event on an empty hole: miss_pulse=1, no state change.
- Hit and expiry on the same hole in the same cycle: the hit wins. hit_pulse=1; escape_pulse is not raised for that hole.
- Hit events are processed in RUN and DRAIN.
- RUN with game_end=1 -> DRAIN. The spawn_tick of that cycle still ages moles but does not spawn.
- DRAIN: no spawns; aging and hits continue. When moles_active==0 -> IDLE with done_pulse=1. start is ignored in DRAIN.
- active_count is always the popcount of moles_active (registered, consistent same cycle).
- Width rules: life counters are unsigned LIFE_W, saturating at 0. Out-of-range encodings of rand_sel/hit_sel never index a hole.

Optional Feature:
- Macro: MOLE_SPEEDUP_EN.
- Defined: a 2-bit hit counter, cleared on entry to RUN. Every 4th hit reduces the loaded lifetime by 1, with a floor of 2. Moles already up keep their remaining life.
- Undefined: spawned life is always LIFE_TICKS; no counter is present.

Decomposition:
- Package mole_pkg:
  - state encoding (IDLE/RUN/DRAIN)
  - HIT_NONE=0 and hole-select range constants
  - function sel_to_mask(3-bit -> NUM_HOLES one-hot, 0 when invalid)
- Sub-module mole_slot, instantiated NUM_HOLES times:
  - holds active bit and life counter
  - inputs: load, tick, kill
  - outputs: active, expire

Test Plan:
- Reset then start=1, spawn_tick with rand_sel=2 -> moles_active=5'b00100 one cycle later, active_count=1, busy=1.
- Mole at hole 3, 8 ticks with rand_sel=7 -> bit clears on 8th tick, escape_pulse exactly one cycle, no hit_pulse.
- Mole at hole 1, hit_sel 0->1 held 20 cycles -> one hit_pulse, moles_active=0; then hit_sel 1->2 -> one miss_pulse.
- MAX_ACTIVE=2, holes 1 and 2 up, tick with rand_sel=4 -> no spawn, mask stays 5'b00011.
- Hole 4 at life 1, hit_sel=4 event on the same cycle as spawn_tick -> hit_pulse=1, escape_pulse=0.
- game_end with moles at holes 2 and 5 -> no new spawns; after both retire, done_pulse=1 once and state IDLE; resetn pulsed low mid-RUN -> all outputs 0 immediately.

Source files
------------

// File: rtl/mole_pkg.sv
// Shared types and helpers for the whack-a-mole scheduler.
// Optional feature macro: MOLE_SPEEDUP_EN (see mole_scheduler).
package mole_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StDrain = 2'd2
  } state_e;

  localparam logic [2:0] HIT_NONE = 3'd0;
  localparam logic [2:0] SEL_MIN  = 3'd1;
  localparam int unsigned MASK_W  = 8;

  // Hole select 1..num_holes -> one-hot; anything else yields an empty mask.
  function automatic logic [MASK_W-1:0] sel_to_mask(input logic [2:0] sel,
                                                    input int unsigned num_holes);
    logic [MASK_W-1:0] m;
    m = '0;
    if (sel != HIT_NONE && 32'(sel) <= num_holes) begin
      m[sel - SEL_MIN] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/mole_slot.sv
// One mole hole: active flag plus a saturating life counter aged by spawn ticks.
module mole_slot #(
  parameter int unsigned LIFE_W = 4
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              clear,
  input  logic              load,
  input  logic              tick,
  input  logic              kill,
  input  logic [LIFE_W-1:0] load_life,
  output logic              active,
  output logic              expire
);

  logic              active_q;
  logic [LIFE_W-1:0] life_q;

  // A same-cycle kill (hit) takes precedence over timing out.
  assign expire = active_q && tick && !kill && (life_q <= LIFE_W'(1));
  assign active = active_q;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      active_q <= 1'b0;
      life_q   <= '0;
    end else if (clear || kill) begin
      active_q <= 1'b0;
      life_q   <= '0;
    end else if (load) begin
      active_q <= 1'b1;
      life_q   <= load_life;
    end else if (tick && active_q) begin
      if (life_q <= LIFE_W'(1)) begin
        active_q <= 1'b0;
        life_q   <= '0;
      end else begin
        life_q <= life_q - LIFE_W'(1);
      end
    end
  end

endmodule

// File: rtl/mole_scheduler.sv
// Whack-a-mole sequencer: spawns, ages and retires moles; emits hit/miss/escape events.
// Define MOLE_SPEEDUP_EN to shorten spawned lifetime by one on every 4th hit (floor 2).
module mole_scheduler
  import mole_pkg::*;
#(
  parameter int unsigned NUM_HOLES  = 5,
  parameter int unsigned LIFE_TICKS = 8,
  parameter int unsigned MAX_ACTIVE = 2,
  parameter int unsigned LIFE_W     = 4
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic                 start,
  input  logic                 game_end,
  input  logic                 spawn_tick,
  input  logic [2:0]           rand_sel,
  input  logic [2:0]           hit_sel,
  output logic [NUM_HOLES-1:0] moles_active,
  output logic                 hit_pulse,
  output logic                 miss_pulse,
  output logic                 escape_pulse,
  output logic [2:0]           active_count,
  output logic                 busy,
  output logic                 done_pulse
);

  state_e               state_q, state_d;
  logic [2:0]           hit_sel_q;
  logic [2:0]           rand_hole;
  logic [NUM_HOLES-1:0] hit_mask, spawn_mask, kill, load, expire;
  logic                 hit_event, hit_on_active, tick, spawn_ok, clear_all;
  logic [LIFE_W-1:0]    life_load;
  logic                 hit_pulse_q, miss_pulse_q, escape_pulse_q, done_pulse_q;

  // rand_sel 0..N-1 maps to hole 1..N; the wrap of 7+1 to 0 lands on "no hole".
  assign rand_hole  = rand_sel + 3'd1;
  assign spawn_mask = NUM_HOLES'(sel_to_mask(rand_hole, NUM_HOLES));
  assign hit_mask   = NUM_HOLES'(sel_to_mask(hit_sel, NUM_HOLES));

  assign hit_event     = (hit_mask != '0) && (hit_sel != hit_sel_q) && (state_q != StIdle);
  assign hit_on_active = (hit_mask & moles_active) != '0;
  assign kill          = hit_event ? hit_mask : '0;
  assign tick          = spawn_tick && (state_q != StIdle);

  always_comb begin
    active_count = '0;
    for (int i = 0; i < NUM_HOLES; i++) begin
      active_count = active_count + {2'b00, moles_active[i]};
    end
  end

  assign spawn_ok = (state_q == StRun) && !game_end && spawn_tick
                 && (spawn_mask != '0)
                 && ((spawn_mask & moles_active) == '0)
                 && ((spawn_mask & kill) == '0)
                 && (32'(active_count) < MAX_ACTIVE);
  assign load = spawn_ok ? spawn_mask : '0;

  always_comb begin
    state_d   = state_q;
    clear_all = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d   = StRun;
          clear_all = 1'b1;
        end
      end
      StRun:   if (game_end) state_d = StDrain;
      StDrain: if (moles_active == '0) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state_q <= StIdle;
    else         state_q <= state_d;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      hit_sel_q      <= HIT_NONE;
      hit_pulse_q    <= 1'b0;
      miss_pulse_q   <= 1'b0;
      escape_pulse_q <= 1'b0;
      done_pulse_q   <= 1'b0;
    end else begin
      hit_sel_q      <= hit_sel;
      hit_pulse_q    <= hit_event && hit_on_active;
      miss_pulse_q   <= hit_event && !hit_on_active;
      escape_pulse_q <= expire != '0;
      done_pulse_q   <= (state_q == StDrain) && (moles_active == '0);
    end
  end

`ifdef MOLE_SPEEDUP_EN
  logic [1:0]        hit_cnt_q;
  logic [LIFE_W-1:0] life_load_q;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      hit_cnt_q   <= '0;
      life_load_q <= LIFE_W'(LIFE_TICKS);
    end else if (clear_all) begin
      hit_cnt_q   <= '0;
      life_load_q <= LIFE_W'(LIFE_TICKS);
    end else if (hit_event && hit_on_active) begin
      hit_cnt_q <= hit_cnt_q + 2'd1;
      if (hit_cnt_q == 2'd3 && life_load_q > LIFE_W'(2)) begin
        life_load_q <= life_load_q - LIFE_W'(1);
      end
    end
  end

  assign life_load = life_load_q;
`else
  assign life_load = LIFE_W'(LIFE_TICKS);
`endif

  for (genvar i = 0; i < NUM_HOLES; i++) begin : g_slot
    mole_slot #(
      .LIFE_W(LIFE_W)
    ) u_slot (
      .clock    (clock),
      .resetn   (resetn),
      .clear    (clear_all),
      .load     (load[i]),
      .tick     (tick),
      .kill     (kill[i]),
      .load_life(life_load),
      .active   (moles_active[i]),
      .expire   (expire[i])
    );
  end

  assign hit_pulse    = hit_pulse_q;
  assign miss_pulse   = miss_pulse_q;
  assign escape_pulse = escape_pulse_q;
  assign done_pulse   = done_pulse_q;
  assign busy         = (state_q != StIdle);

endmodule
